// File: rtl/test_split_responder.sv
// Split-bus target: byte-enabled word memory with an in-order read
// response queue that returns data a fixed number of cycles after accept.
module test_split_responder #(
    parameter int MEM_POW      = 10,
    parameter int RESP_LATENCY = 4,
    parameter int PEND_POW     = 3
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        host_req,
    output logic        host_ack,
    input  logic        host_we,
    input  logic [31:0] host_addr,
    input  logic [31:0] host_wdata,
    input  logic [3:0]  host_be,
    output logic        host_resp,
    output logic [31:0] host_rdata
);
    localparam int DEPTH = 1 << PEND_POW;
    localparam int WORDS = 1 << MEM_POW;
    localparam logic [PEND_POW:0] FULL = (PEND_POW + 1)'(DEPTH);
    localparam logic [7:0] DLY_INIT = 8'(RESP_LATENCY - 1);

    logic [31:0]         mem_q  [WORDS];
    logic [31:0]         data_q [DEPTH];
    logic [7:0]          dly_q  [DEPTH];
    logic [7:0]          dly_d  [DEPTH];
    logic [PEND_POW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PEND_POW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PEND_POW:0]   count_q, count_d;
    logic [MEM_POW-1:0]  idx;
    logic                pop, push, wr_acc;
    logic                unused_addr;

    assign idx         = host_addr[MEM_POW+1:2];
    assign unused_addr = ^{host_addr[31:MEM_POW+2], host_addr[1:0]};

    assign pop      = (count_q != '0) && (dly_q[rd_ptr_q] == '0);
    assign host_ack = host_req && !rst_i && ((count_q != FULL) || pop);
    assign push     = host_ack && !host_we;
    assign wr_acc   = host_ack && host_we;

    assign host_resp  = pop && !rst_i;
    assign host_rdata = host_resp ? data_q[rd_ptr_q] : '0;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        for (int i = 0; i < DEPTH; i++) begin
            dly_d[i] = (dly_q[i] != '0) ? dly_q[i] - 8'd1 : 8'd0;
        end
        if (push) begin
            dly_d[wr_ptr_q] = DLY_INIT;
            wr_ptr_d        = wr_ptr_q + PEND_POW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PEND_POW'(1);
        end
        unique case ({push, pop})
            2'b10:   count_d = count_q + (PEND_POW + 1)'(1);
            2'b01:   count_d = count_q - (PEND_POW + 1)'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                dly_q[i] <= '0;
            end
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            for (int i = 0; i < DEPTH; i++) begin
                dly_q[i] <= dly_d[i];
            end
        end
    end

    // Memory and captured read data survive reset; only queue control clears.
    always_ff @(posedge clk_i) begin
        if (wr_acc) begin
            for (int b = 0; b < 4; b++) begin
                if (host_be[b]) begin
                    mem_q[idx][8*b +: 8] <= host_wdata[8*b +: 8];
                end
            end
        end
        if (push) begin
            data_q[wr_ptr_q] <= mem_q[idx];
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            assert (!(host_resp && (count_q == '0)));
        end
    end

endmodule

// File: doc/test_split_responder.md
Name: test_split_responder

Overview:
- Target-side responder model for the split-transaction req/ack/resp bus; it terminates the host port of a request/response path.
- Accepts requests with a combinational ack and services writes into an internal word memory with byte enables.
- Returns read data in order on a separate resp/rdata channel after a fixed programmable latency.
- Used as the memory endpoint in split-bus testbenches, behind a delayer or directly behind a bus master.

Parameters:
- MEM_POW, 10, memory holds 2^MEM_POW 32-bit words, indexed by host_addr[MEM_POW+1:2].
- RESP_LATENCY, 4, cycles from read accept to host_resp; legal range 1..255.
- PEND_POW, 3, pending-read queue holds 2^PEND_POW entries.

Ports:
- clk_i  input  1  clock, all state on rising edge.
- rst_i  input  1  reset, asynchronous, active-high.
- host_req  input  1  request valid.
- host_ack  output  1  request accepted this cycle (combinational).
- host_we  input  1  1 = write, 0 = read.
- host_addr  input  32  byte address; bits [1:0] and bits above MEM_POW+1 are ignored (memory aliases).
- host_wdata  input  32  write data.
- host_be  input  4  byte enables; be[i] qualifies wdata[8i+7:8i].
- host_resp  output  1  read response valid, one cycle per read.
- host_rdata  output  32  read data; 0 when host_resp = 0.

Behaviour:
- Clock and reset: one clock, clk_i; reset rst_i is asynchronous and active-high.
- While rst_i = 1:
  - host_ack = 0, host_resp = 0, host_rdata = 0.
  - The queue is emptied and all delay counters are cleared.
  - Memory contents are not reset.
- Accept rule: host_ack = host_req && !rst_i && (count < 2^PEND_POW || pop_this_cycle).
  - A full queue that pops in the same cycle still accepts.
  - A transfer occurs on a rising edge with host_req && host_ack.
  - Request fields are sampled only in that cycle.
- Write accept:
  - Bytes with be = 1 are written to mem[addr[MEM_POW+1:2]] at the accepting edge.
  - be = 0000 leaves memory unchanged.
  - Writes produce no response.
  - The written data is visible to a read accepted in the next cycle or later.
- Read accept:
  - The memory word is read at the accepting edge (full word; be is ignored).
  - The word is pushed to the queue tail with delay counter = RESP_LATENCY-1.
- Queue:
  - Circular buffer with wr_ptr, rd_ptr and count (PEND_POW+1 bits); pointers wrap modulo 2^PEND_POW.
  - Every valid entry's counter decrements by 1 each cycle, saturating at 0.
  - pop_this_cycle = (count != 0) && (head counter == 0).
  - When pop_this_cycle = 1: host_resp = 1, host_rdata = head data, rd_ptr advances, count decrements.
  - A simultaneous push and pop leaves count unchanged.
- Latency: a read accepted at edge N produces host_resp high during the cycle after edge N+RESP_LATENCY-1, i.e. RESP_LATENCY cycles after accept.
  - Back-to-back reads give back-to-back responses.
  - Responses are strictly in accept order; at most one per cycle.
- Capacity:
  - With RESP_LATENCY <= 2^PEND_POW the queue never blocks.
  - Otherwise host_ack drops whenever count = 2^PEND_POW and there is no pop that cycle.
- Interleaving: a read followed by a write to the same address returns the pre-write data, because data is captured at accept.
- Reset mid-operation: pending reads are discarded with no response, and no response is emitted in the cycle rst_i deasserts.
- Checking: a simulation-only assertion fires if host_resp would be raised while count = 0.

Test Plan:
- Write 0xDEADBEEF, be = 1111, addr 0x10; read addr 0x10 -> host_resp exactly 4 cycles after the read ack, rdata = 0xDEADBEEF, host_resp high for one cycle.
- Write 0x11223344, then write 0xAABBCCDD with be = 0101 to the same address, then read -> rdata = 0x11BB33DD.
- 8 consecutive reads of addresses 0x0..0x1C preloaded with value = index -> 8 contiguous resp cycles with rdata 0..7 in order, host_ack continuously high.
- RESP_LATENCY = 12, PEND_POW = 2, host_req held high with reads:
  - host_ack is high for the first 4 cycles, then low until the first resp.
  - Afterwards it is high on each cycle in which a pop occurs.
  - No response is lost or reordered.
- Read addr 0x20 (holding 0x5) and, in the next cycle, write 0x9 to addr 0x20 -> the response returns 0x5; a subsequent read returns 0x9.
- Three reads accepted, then rst_i pulsed asynchronously for 1 cycle before any resp -> no host_resp afterwards, host_ack = 0 during reset, and a new read after reset returns correctly after RESP_LATENCY.
